riego_ctrl: RTL and testbench

RIEGO_CTRL -- requirements
Module: riego_ctrl

---
 rtl/riego_ctrl.sv | 97 +++++++++
 tb/tb_riego_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/riego_ctrl.sv
// riego_ctrl: tank-fed irrigation controller with sprinkler/drip runs, forced rest and sensor-fault alarm.
// Ports:
//   clk, rst_n      system clock (rising edge), asynchronous active-low reset
//   h, m, l         tank probes, 1 = water at or above high/medium/low level
//   u               soil humidity, 1 = moist
//   t               temperature, 1 = above threshold
//   clr             alarm acknowledge (level)
//   ve, vs, vg      inlet, sprinkler, drip valve commands (1 = open)
//   alarm           sensor fault indication
//   st              state code for the display decoders
module riego_ctrl #(
  parameter int MIN_ON = 16,
  parameter int MAX_ON = 1024,
  parameter int REST   = 64,
  parameter int CW     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h,
  input  logic       m,
  input  logic       l,
  input  logic       u,
  input  logic       t,
  input  logic       clr,
  output logic       ve,
  output logic       vs,
  output logic       vg,
  output logic       alarm,
  output logic [2:0] st
);
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ASP   = 3'b001,
    GOT   = 3'b010,
    PAUSE = 3'b011,
    ERR   = 3'b100
  } state_t;
  logic [5:0] s1, s2;
  logic hs, ms, ls, us, ts, cs, bad;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic ve_n, vs_n, vg_n, alarm_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {h, m, l, u, t, clr};
      s2 <= s1;
    end
  assign {hs, ms, ls, us, ts, cs} = s2;
  assign bad = (hs & ~ms) | (ms & ~ls);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (!us && ls) nxt = (ms && !ts) ? ASP : GOT;
      ASP, GOT: if (!ls) nxt = IDLE;
                else if (cnt == CW'(MAX_ON - 1)) nxt = PAUSE;
                else if (us && cnt >= CW'(MIN_ON - 1)) nxt = IDLE;
      PAUSE:    if (cnt == CW'(REST - 1)) nxt = IDLE;
      ERR:      if (cs) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (bad) nxt = ERR;
    // one counter serves both the run and the rest; it restarts on every state change
    cnt_n = (nxt == state && state inside {ASP, GOT, PAUSE}) ? cnt + 1'b1 : '0;
  end
  // outputs are decoded from the next state so they register on the same edge as the state
  always_comb begin
    vs_n    = nxt == ASP;
    vg_n    = nxt == GOT;
    alarm_n = nxt == ERR;
    ve_n    = (nxt == ERR) ? 1'b0 : !ls ? 1'b1 : hs ? 1'b0 : ve;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ve    <= 1'b0;
      vs    <= 1'b0;
      vg    <= 1'b0;
      alarm <= 1'b0;
      st    <= 3'b000;
    end else begin
      ve    <= ve_n;
      vs    <= vs_n;
      vg    <= vg_n;
      alarm <= alarm_n;
      st    <= nxt;
    end
endmodule

// File: tb/tb_riego_ctrl.sv
// tb_riego_ctrl: directed and random checks of riego_ctrl against a cycle-level behavioural model.
module tb_riego_ctrl;
  localparam int MIN_ON = 16;
  localparam int MAX_ON = 1024;
  localparam int REST   = 64;
  logic clk = 0, rst_n = 0;
  logic h = 0, m = 0, l = 0, u = 0, t = 0, clr = 0;
  logic ve, vs, vg, alarm;
  logic [2:0] st;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  riego_ctrl dut (
    .clk(clk), .rst_n(rst_n), .h(h), .m(m), .l(l), .u(u), .t(t), .clr(clr),
    .ve(ve), .vs(vs), .vg(vg), .alarm(alarm), .st(st)
  );
  typedef enum int {M_IDLE = 0, M_ASP = 1, M_GOT = 2, M_PAUSE = 3, M_ERR = 4} mode_t;
  mode_t mode = M_IDLE;
  int el = 0;
  bit mve = 0;
  logic [5:0] q[$];
  function automatic void model_step(logic [5:0] v);
    bit vh, vm, vl, vu, vt, vc;
    mode_t nm;
    {vh, vm, vl, vu, vt, vc} = v;
    nm = mode;
    if ((vh && !vm) || (vm && !vl)) nm = M_ERR;
    else if (mode == M_IDLE) begin
      if (!vu && vl) nm = (vm && !vt) ? M_ASP : M_GOT;
    end else if (mode == M_ASP || mode == M_GOT) begin
      if (!vl) nm = M_IDLE;
      else if (el == MAX_ON) nm = M_PAUSE;
      else if (vu && el >= MIN_ON) nm = M_IDLE;
    end else if (mode == M_PAUSE) begin
      if (el == REST) nm = M_IDLE;
    end else if (vc) nm = M_IDLE;
    el = (nm != mode) ? 1 : el + 1;
    mode = nm;
    if (mode == M_ERR) mve = 0;
    else if (!vl) mve = 1;
    else if (vh) mve = 0;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode = M_IDLE;
      el = 0;
      mve = 0;
      q = '{6'd0, 6'd0, 6'd0};
    end else begin
      q.push_front({h, m, l, u, t, clr});
      model_step(q[2]);
      void'(q.pop_back());
    end
  function automatic logic [6:0] model_out();
    return {mve, mode == M_ASP, mode == M_GOT, mode == M_ERR, 3'(int'(mode))};
  endfunction
  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("cycle", {ve, vs, vg, alarm, st}, model_out());
    end
  endtask
  logic [2:0] lvls [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
  initial begin
    #2;
    chk("reset", {ve, vs, vg, alarm, st}, 7'd0);
    #11 rst_n = 1;
    step(4);
    {h, m, l, u, t} = 5'b11100;
    step(3);
    chk("asp_entry", {3'b0, vs, st}, {3'b0, 1'b1, 3'b001});
    step(4);
    u = 1;
    step(25);
    chk("asp_done", {4'b0, st}, 7'd0);
    {h, m, l, u, t} = 5'b00100;
    step(3);
    chk("got_entry", {3'b0, vg, st}, {3'b0, 1'b1, 3'b010});
    step(1030);
    chk("pause", {1'b0, vs, vg, 1'b0, st}, {1'b0, 1'b0, 1'b0, 1'b0, 3'b011});
    step(70);
    chk("got_again", {3'b0, vg, st}, {3'b0, 1'b1, 3'b010});
    l = 0;
    step(3);
    chk("dry", {ve, 1'b0, vg, 1'b0, st}, {1'b1, 1'b0, 1'b0, 1'b0, 3'b000});
    l = 1;
    step(5);
    m = 1;
    step(5);
    h = 1;
    step(2);
    chk("ve_hold", {6'b0, ve}, 7'd1);
    step(1);
    chk("ve_clear", {6'b0, ve}, 7'd0);
    u = 1;
    step(MIN_ON + 5);
    u = 0;
    step(3);
    chk("asp_again", {4'b0, st}, 7'd1);
    m = 0;
    step(3);
    chk("err", {ve, vs, vg, alarm, st}, {4'b0001, 3'b100});
    clr = 1;
    step(5);
    chk("err_hold", {ve, vs, vg, alarm, st}, {4'b0001, 3'b100});
    h = 0;
    u = 1;
    step(3);
    chk("err_exit", {3'b0, alarm, st}, 7'd0);
    clr = 0;
    {h, m, l, u, t} = 5'b11100;
    step(10);
    chk("asp_pre_rst", {4'b0, st}, 7'd1);
    #3 rst_n = 0;
    #1;
    chk("async_rst", {ve, vs, vg, alarm, st}, 7'd0);
    chk("async_rst_model", {ve, vs, vg, alarm, st}, model_out());
    #3 rst_n = 1;
    step(3);
    chk("fresh_asp", {4'b0, st}, 7'd1);
    step(MIN_ON + 2);
    for (int i = 0; i < 300; i++) begin
      {h, m, l} = ($urandom_range(0, 9) < 8) ? lvls[$urandom_range(0, 3)] : 3'($urandom);
      u = $urandom_range(0, 2) == 0;
      t = 1'($urandom);
      clr = $urandom_range(0, 3) == 0;
      step($urandom_range(1, 20));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
